// File: rtl/retire_drain_sched.sv
// Drains the lockstep per-commit-port ingress FIFOs one bundle at a time.
// Valid lanes of the head bundle are presented lowest lane first on a
// single-lane valid/ready stream. A common pop is issued when the bundle is
// exhausted, and flush discards every buffered bundle.
module retire_drain_sched #(
  parameter int NRET  = 2,
  parameter int SEL_W = (NRET > 1) ? $clog2(NRET) : 1,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fifo_empty_i,
  input  logic [NRET-1:0]  head_valid_i,
  input  logic             lane_ready_i,
  input  logic             flush_i,
  output logic             lane_valid_o,
  output logic [SEL_W-1:0] lane_sel_o,
  output logic             lane_last_o,
  output logic             pop_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  typedef enum logic [1:0] {IDLE, SERVE, FLUSH} state_t;

  state_t           state_q;
  logic [NRET-1:0]  done_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pop_q;

  logic             serve_live;
  logic [NRET-1:0]  pending;
  logic [SEL_W-1:0] sel;
  logic             hs;

  // Lanes still owed from the head bundle; a flush cycle presents nothing,
  // which is what lets flush win over a handshake in the same cycle.
  always_comb begin
    serve_live = (state_q == SERVE) && !flush_i && !fifo_empty_i;
    pending    = '0;
    if (serve_live) begin
      pending = head_valid_i & ~done_q;
    end
  end

  // Lowest pending lane: the scan runs high-to-low so the last hit wins.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NRET; i++) begin
      if (pending[NRET-1-i]) begin
        sel = SEL_W'(NRET - 1 - i);
      end
    end
  end

  // Stream outputs and the common pop strobe.
  always_comb begin
    lane_valid_o  = |pending;
    lane_sel_o    = sel;
    lane_last_o   = (pending != '0) && ((pending & (pending - NRET'(1))) == '0);
    hs            = lane_valid_o && lane_ready_i;
    pop_o         = (serve_live && ((pending == '0) || (hs && lane_last_o))) ||
                    ((state_q == FLUSH) && !fifo_empty_i);
    busy_o        = (state_q != IDLE);
    retired_cnt_o = cnt_q;
  end

  // Sequencer state, per-bundle served-lane mask and the retired counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      done_q  <= '0;
      cnt_q   <= '0;
      pop_q   <= 1'b0;
    end else begin
      pop_q <= pop_o;
      if (hs) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (flush_i) begin
        done_q  <= '0;
        state_q <= fifo_empty_i ? IDLE : FLUSH;
      end else begin
        case (state_q)
          IDLE: begin
            if (!fifo_empty_i) state_q <= SERVE;
          end
          SERVE: begin
            if (fifo_empty_i) begin
              state_q <= IDLE;
            end else if (hs) begin
              if (lane_last_o) done_q <= '0;
              else             done_q[lane_sel_o] <= 1'b1;
            end
          end
          FLUSH: begin
            if (fifo_empty_i) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // The FIFO can only run dry in SERVE as the result of our own pop.
  a_no_empty_without_pop: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
      ((state_q == SERVE) && fifo_empty_i) |-> pop_q
  );

endmodule

// File: tb/tb_retire_drain_sched.sv
// Bench for retire_drain_sched: a queue-based FIFO environment plus a
// bundle-level reference model (lanes owed = popcount(head) - lanes taken).
module tb_retire_drain_sched;

  localparam int NRET  = 2;
  localparam int SEL_W = 1;

  typedef enum int {M_IDLE, M_SERVE, M_FLUSH} mode_t;

  logic             clk          = 1'b0;
  logic             rst_ni       = 1'b0;
  logic             fifo_empty_i = 1'b1;
  logic [NRET-1:0]  head_valid_i = '0;
  logic             lane_ready_i = 1'b0;
  logic             flush_i      = 1'b0;

  logic             lane_valid_o, lane_last_o, pop_o, busy_o;
  logic [SEL_W-1:0] lane_sel_o;
  logic [15:0]      retired_cnt_o;

  logic             lane_valid_w, lane_last_w, pop_w, busy_w;
  logic [SEL_W-1:0] lane_sel_w;
  logic [3:0]       retired_cnt_w;

  retire_drain_sched #(.NRET(NRET), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .fifo_empty_i(fifo_empty_i),
    .head_valid_i(head_valid_i), .lane_ready_i(lane_ready_i), .flush_i(flush_i),
    .lane_valid_o(lane_valid_o), .lane_sel_o(lane_sel_o), .lane_last_o(lane_last_o),
    .pop_o(pop_o), .busy_o(busy_o), .retired_cnt_o(retired_cnt_o)
  );

  retire_drain_sched #(.NRET(NRET), .CNT_W(4)) dut_w (
    .clk_i(clk), .rst_ni(rst_ni), .fifo_empty_i(fifo_empty_i),
    .head_valid_i(head_valid_i), .lane_ready_i(lane_ready_i), .flush_i(flush_i),
    .lane_valid_o(lane_valid_w), .lane_sel_o(lane_sel_w), .lane_last_o(lane_last_w),
    .pop_o(pop_w), .busy_o(busy_w), .retired_cnt_o(retired_cnt_w)
  );

  always #5 clk = ~clk;

  int unsigned     vectors     = 0;
  int unsigned     miscompares = 0;
  int unsigned     pop_seen    = 0;
  logic [NRET-1:0] fifo_q[$];
  logic [NRET-1:0] push_q[$];
  mode_t           mode  = M_IDLE;
  int              acc   = 0;
  int unsigned     m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty_i = (fifo_q.size() == 0);
    head_valid_i = fifo_empty_i ? '0 : fifo_q[0];
  endtask

  function automatic int nth_set(input logic [NRET-1:0] v, input int n);
    int k = 0;
    for (int i = 0; i < NRET; i++) begin
      if (v[i]) begin
        if (k == n) return i;
        k++;
      end
    end
    return 0;
  endfunction

  task automatic reset_model();
    mode  = M_IDLE;
    acc   = 0;
    m_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, lane_valid_o}, 0);
    check({tag, "_sel"},   {31'd0, lane_sel_o},   0);
    check({tag, "_last"},  {31'd0, lane_last_o},  0);
    check({tag, "_pop"},   {31'd0, pop_o},        0);
    check({tag, "_busy"},  {31'd0, busy_o},       0);
    check({tag, "_cnt"},   {16'd0, retired_cnt_o}, 0);
    check({tag, "_cnt_w"}, {28'd0, retired_cnt_w}, 0);
    check({tag, "_valid_w"}, {31'd0, lane_valid_w}, 0);
  endtask

  // One clock: entered at posedge+1 with ready/flush set by the caller.
  task automatic cycle();
    bit              empty, e_valid, e_last, e_pop, hs;
    int              e_sel, npend;
    logic [NRET-1:0] head;
    drive_fifo();
    @(negedge clk);
    empty   = (fifo_q.size() == 0);
    head    = empty ? '0 : fifo_q[0];
    e_valid = 0; e_last = 0; e_pop = 0; e_sel = 0;
    if (mode == M_SERVE && !flush_i && !empty) begin
      npend = $countones(head) - acc;
      if (npend > 0) begin
        e_valid = 1;
        e_sel   = nth_set(head, acc);
        e_last  = (npend == 1);
        e_pop   = lane_ready_i && e_last;
      end else begin
        e_pop = 1;
      end
    end else if (mode == M_FLUSH) begin
      e_pop = !empty;
    end
    if (pop_o === 1'b1) pop_seen++;
    check("valid",   {31'd0, lane_valid_o}, {31'd0, e_valid});
    check("sel",     {31'd0, lane_sel_o},   e_sel);
    check("last",    {31'd0, lane_last_o},  {31'd0, e_last});
    check("pop",     {31'd0, pop_o},        {31'd0, e_pop});
    check("busy",    {31'd0, busy_o},       {31'd0, (mode != M_IDLE)});
    check("cnt",     {16'd0, retired_cnt_o}, m_cnt & 32'hFFFF);
    check("valid_w", {31'd0, lane_valid_w}, {31'd0, e_valid});
    check("sel_w",   {31'd0, lane_sel_w},   e_sel);
    check("last_w",  {31'd0, lane_last_w},  {31'd0, e_last});
    check("pop_w",   {31'd0, pop_w},        {31'd0, e_pop});
    check("busy_w",  {31'd0, busy_w},       {31'd0, (mode != M_IDLE)});
    check("cnt_w",   {28'd0, retired_cnt_w}, m_cnt & 32'hF);
    hs = e_valid && lane_ready_i;
    if (hs) begin
      m_cnt++;
      acc++;
    end
    if (e_pop) acc = 0;
    if (flush_i) begin
      acc  = 0;
      mode = empty ? M_IDLE : M_FLUSH;
    end else begin
      case (mode)
        M_IDLE:  if (!empty) mode = M_SERVE;
        M_SERVE: if (empty)  mode = M_IDLE;
        M_FLUSH: if (empty)  mode = M_IDLE;
        default: mode = M_IDLE;
      endcase
    end
    @(posedge clk);
    if (e_pop) void'(fifo_q.pop_front());
    while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
    #1;
  endtask

  initial begin
    int unsigned p0;

    // Reset state
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_ni = 1'b1;
    reset_model();

    // Two-lane bundle, always ready
    lane_ready_i = 1'b1;
    push_q.push_back(2'b11);
    repeat (6) cycle();
    check("t1_cnt", {16'd0, retired_cnt_o}, 2);

    // Lane 1 only, downstream stalls three presented cycles
    lane_ready_i = 1'b0;
    push_q.push_back(2'b10);
    repeat (5) cycle();
    lane_ready_i = 1'b1;
    repeat (3) cycle();

    // Empty / single / empty bundles
    push_q.push_back(2'b00);
    push_q.push_back(2'b01);
    push_q.push_back(2'b00);
    repeat (7) cycle();
    check("t3_cnt",  {16'd0, retired_cnt_o}, 4);
    check("t3_busy", {31'd0, busy_o}, 0);

    // Flush after lane 0 of a four-bundle backlog
    push_q.push_back(2'b11);
    push_q.push_back(2'b01);
    push_q.push_back(2'b10);
    push_q.push_back(2'b11);
    repeat (3) cycle();
    p0 = pop_seen;
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    repeat (6) cycle();
    check("t4_pops", pop_seen - p0, 4);
    check("t4_cnt",  {16'd0, retired_cnt_o}, 5);
    check("t4_busy", {31'd0, busy_o}, 0);

    // Counter wrap on the 4-bit instance
    rst_ni = 1'b0;
    #3;
    check_all_zero("rst2");
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    reset_model();
    for (int i = 0; i < 17; i++) push_q.push_back(2'b01);
    repeat (22) cycle();
    check("wrap_cnt_w", {28'd0, retired_cnt_w}, 1);
    check("wrap_cnt",   {16'd0, retired_cnt_o}, 17);

    // Asynchronous reset while a lane is presented
    lane_ready_i = 1'b0;
    push_q.push_back(2'b11);
    repeat (3) cycle();
    check("pre_rst_valid", {31'd0, lane_valid_o}, 1);
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_rst");
    reset_model();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    lane_ready_i = 1'b1;
    repeat (4) cycle();

    // Randomised traffic with occasional flush
    repeat (600) begin
      lane_ready_i = ($urandom_range(0, 3) != 0);
      flush_i      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) push_q.push_back(NRET'($urandom));
      cycle();
    end

    // Bounded drain
    flush_i      = 1'b0;
    lane_ready_i = 1'b1;
    for (int i = 0; i < 400 && (fifo_q.size() != 0 || mode != M_IDLE); i++) cycle();
    check("drain_busy", {31'd0, busy_o}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
